// File: rtl/button_drive_ctrl.sv
// Push-button front end: 2-flop sync + debounce, conflict resolution, throttle FSM with stop dwell.
// Latency: pin->btn_db 2+DB_CYCLES, btn_db->direction/throttle 1 cycle; no backpressure, outputs free-running.
module button_drive_ctrl #(
    parameter int DB_CYCLES    = 50000,
    parameter int DWELL_CYCLES = 25000,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fwd,
    input  logic       btn_rev,
    input  logic       estop,
    output logic [1:0] direction,
    output logic [1:0] throttle,
    output logic [3:0] btn_db,
    output logic       dwell_active
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_FWD   = 2'd1,
        ST_REV   = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    logic [4:0]       raw;
    logic [4:0]       s1_q;
    logic [4:0]       s2_q;
    logic [3:0]       db_q;
    logic [3:0]       db_d;
    logic [CNT_W-1:0] db_cnt_q [4];
    logic [CNT_W-1:0] db_cnt_d [4];
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] dwell_cnt_q;
    logic [CNT_W-1:0] dwell_cnt_d;
    logic [1:0]       throttle_q;
    logic [1:0]       throttle_d;
    logic             dwell_q;
    logic             dwell_d;
    logic             e_sync;
    logic             fwd_req;
    logic             rev_req;

    // Bit 4 is the e-stop: synchronised only, never debounced.
    assign raw = {estop, btn_rev, btn_fwd, btn_right, btn_left};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = s2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        case (db_q[1:0])
            2'b01:   dir_d = 2'd1;
            2'b10:   dir_d = 2'd2;
            default: dir_d = 2'd3;
        endcase
    end

    assign e_sync  = s2_q[4];
    assign fwd_req = db_q[2] & ~db_q[3];
    assign rev_req = db_q[3] & ~db_q[2];

    // Every exit from FWD/REV lands in DWELL, so a reversal can never skip the stop dwell.
    always_comb begin
        state_d     = state_q;
        dwell_cnt_d = dwell_cnt_q;
        if (e_sync) begin
            state_d     = ST_DWELL;
            dwell_cnt_d = '0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    dwell_cnt_d = '0;
                    if (fwd_req) begin
                        state_d = ST_FWD;
                    end else if (rev_req) begin
                        state_d = ST_REV;
                    end
                end
                ST_FWD: begin
                    dwell_cnt_d = '0;
                    if (!fwd_req) begin
                        state_d = ST_DWELL;
                    end
                end
                ST_REV: begin
                    dwell_cnt_d = '0;
                    if (!rev_req) begin
                        state_d = ST_DWELL;
                    end
                end
                default: begin
                    if (dwell_cnt_q == DWELL_LAST) begin
                        state_d     = ST_STOP;
                        dwell_cnt_d = '0;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
            endcase
        end

        case (state_d)
            ST_FWD:  throttle_d = 2'd2;
            ST_REV:  throttle_d = 2'd1;
            default: throttle_d = 2'd3;
        endcase
        dwell_d = (state_d == ST_DWELL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOP;
            dwell_cnt_q <= '0;
            throttle_q  <= 2'd3;
            dwell_q     <= 1'b0;
            dir_q       <= 2'd3;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            throttle_q  <= throttle_d;
            dwell_q     <= dwell_d;
            dir_q       <= dir_d;
        end
    end

    assign direction    = dir_q;
    assign throttle     = throttle_q;
    assign btn_db       = db_q;
    assign dwell_active = dwell_q;

endmodule

// File: tb/tb_button_drive_ctrl.sv
// Bench for button_drive_ctrl with DB_CYCLES=4, DWELL_CYCLES=6: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_button_drive_ctrl;

    localparam int DB    = 4;
    localparam int DWELL = 6;
    localparam int MD_STOP = 0, MD_FWD = 1, MD_REV = 2, MD_DWELL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_fwd = 1'b0, btn_rev = 1'b0, estop = 1'b0;
    logic [1:0] direction, throttle;
    logic [3:0] btn_db;
    logic       dwell_active;

    int checks = 0;
    int errors = 0;

    button_drive_ctrl #(.DB_CYCLES(DB), .DWELL_CYCLES(DWELL), .CNT_W(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fwd(btn_fwd), .btn_rev(btn_rev),
        .estop(estop),
        .direction(direction), .throttle(throttle), .btn_db(btn_db), .dwell_active(dwell_active)
    );

    always #5 clk = ~clk;

    // Behavioural model: a button's debounced value flips once the last DB synchronised samples
    // all disagree with it; the dwell is a countdown of remaining stop cycles.
    bit [4:0]   m_s1, m_s2;
    bit [3:0]   m_db;
    bit         m_hist [4][$];
    int         m_mode, m_left;
    logic [1:0] m_dir;

    function automatic void model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        for (int i = 0; i < 4; i++) m_hist[i].delete();
        m_mode = MD_STOP; m_left = 0; m_dir = 2'd3;
    endfunction

    function automatic void model_step();
        bit e, f, r, all_diff;
        e = m_s2[4]; f = m_db[2]; r = m_db[3];
        if (m_db[0] && !m_db[1])      m_dir = 2'd1;
        else if (m_db[1] && !m_db[0]) m_dir = 2'd2;
        else                          m_dir = 2'd3;
        if (e) begin
            m_mode = MD_DWELL; m_left = DWELL;
        end else if (m_mode == MD_STOP) begin
            if (f && !r)      m_mode = MD_FWD;
            else if (r && !f) m_mode = MD_REV;
        end else if (m_mode == MD_FWD || m_mode == MD_REV) begin
            if ((m_mode == MD_FWD && !(f && !r)) || (m_mode == MD_REV && !(r && !f))) begin
                m_mode = MD_DWELL; m_left = DWELL;
            end
        end else begin
            if (m_left == 1) m_mode = MD_STOP;
            else             m_left = m_left - 1;
        end
        for (int i = 0; i < 4; i++) begin
            m_hist[i].push_back(m_s2[i]);
            if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
            if (m_hist[i].size() == DB) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) if (m_hist[i][k] == m_db[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[i] = ~m_db[i];
                    m_hist[i].delete();
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = {estop, btn_rev, btn_fwd, btn_right, btn_left};
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [1:0] t;
        t = (m_mode == MD_FWD) ? 2'd2 : (m_mode == MD_REV) ? 2'd1 : 2'd3;
        return {m_dir, t, m_db, (m_mode == MD_DWELL)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
    endtask

    task automatic test_reset();
        bit seen;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({direction, throttle, btn_db, dwell_active} !== 9'b11_11_0000_0) begin
            errors++; $display("FAIL reset_initial got=%b exp=%b", {direction, throttle, btn_db, dwell_active}, 9'b11_11_0000_0);
        end
        repeat (2) tick();
        #2 rst_n = 1'b1;
        btn_fwd = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL reset_run t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (throttle == 2'd2) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_fwd_timeout throttle=%0d exp=2", throttle); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({direction, throttle, btn_db, dwell_active} !== 9'b11_11_0000_0) begin
            errors++; $display("FAIL reset_async got=%b exp=%b", {direction, throttle, btn_db, dwell_active}, 9'b11_11_0000_0);
        end
        repeat (3) tick();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL reset_release t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (btn_db[2] !== (k == 6)) begin
                    errors++; $display("FAIL reset_fresh_count k=%0d btn_db_fwd=%b exp=%b", k, btn_db[2], (k == 6));
                end
            end
        end
        btn_fwd = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_debounce();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 6; k++) begin
                btn_left = (k < 3);
                tick();
                checks++;
                if ({direction, throttle, btn_db, dwell_active} !== exp_vec() || btn_db[0] !== 1'b0 || direction !== 2'd3) begin
                    errors++; $display("FAIL debounce_glitch t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
                end
            end
        end
        btn_left = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL debounce_hold t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (k >= 5 && k <= 7) begin
                checks++;
                if (btn_db[0] !== (k >= 6) || direction !== ((k >= 7) ? 2'd1 : 2'd3)) begin
                    errors++; $display("FAIL debounce_latency k=%0d db=%b dir=%0d exp db=%b dir=%0d", k, btn_db[0], direction, (k >= 6), (k >= 7) ? 1 : 3);
                end
            end
        end
        btn_left = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_conflict();
        btn_left = 1'b1; btn_right = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL conflict_lr t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
        end
        checks++;
        if (btn_db[1:0] !== 2'b11 || direction !== 2'd3) begin
            errors++; $display("FAIL conflict_dir db=%b dir=%0d exp db=11 dir=3", btn_db[1:0], direction);
        end
        btn_left = 1'b0; btn_right = 1'b0; btn_fwd = 1'b1; btn_rev = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL conflict_fr t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
        end
        checks++;
        if (btn_db[3:2] !== 2'b11 || throttle !== 2'd3 || dwell_active !== 1'b0) begin
            errors++; $display("FAIL conflict_thr db=%b thr=%0d dwell=%b exp db=11 thr=3 dwell=0", btn_db[3:2], throttle, dwell_active);
        end
        btn_fwd = 1'b0; btn_rev = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reversal();
        bit seen, done;
        int run;
        btn_fwd = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL reversal_fwd t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (throttle == 2'd2) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reversal_fwd_timeout throttle=%0d exp=2", throttle); end
        btn_fwd = 1'b0; btn_rev = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL reversal_enter t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (dwell_active) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reversal_dwell_timeout dwell_active=%b exp=1", dwell_active); end
        run = 1; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL reversal_dwell t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (dwell_active) run++;
            else              done = 1'b1;
        end
        checks++;
        if (run != DWELL || throttle !== 2'd3) begin
            errors++; $display("FAIL reversal_dwell_len cycles=%0d thr=%0d exp cycles=%0d thr=3", run, throttle, DWELL);
        end
        tick();
        checks++;
        if (throttle !== 2'd1 || exp_vec() !== {direction, throttle, btn_db, dwell_active}) begin
            errors++; $display("FAIL reversal_rev thr=%0d exp=1", throttle);
        end
    endtask

    task automatic test_estop();
        for (int k = 1; k <= 10; k++) begin
            estop = 1'b1;
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL estop_hold t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (k >= 3) begin
                checks++;
                if (throttle !== 2'd3 || dwell_active !== 1'b1) begin
                    errors++; $display("FAIL estop_react k=%0d thr=%0d dwell=%b exp thr=3 dwell=1", k, throttle, dwell_active);
                end
            end
        end
        estop = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec()) begin
                errors++; $display("FAIL estop_release t=%0t got=%b exp=%b", $time, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (k >= 7) begin
                checks++;
                if (dwell_active !== (k == 7) || throttle !== ((k == 9) ? 2'd1 : 2'd3)) begin
                    errors++; $display("FAIL estop_stop k=%0d thr=%0d dwell=%b exp thr=%0d dwell=%b", k, throttle, dwell_active, (k == 9) ? 1 : 3, (k == 7));
                end
            end
        end
        btn_rev = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_simultaneity();
        bit seen;
        btn_rev = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (throttle == 2'd1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL simul_rev_timeout throttle=%0d exp=1", throttle); end
        btn_rev = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 8) btn_fwd = 1'b1;
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec() || throttle == 2'd0 || direction == 2'd0) begin
                errors++; $display("FAIL simul_seq k=%0d got=%b exp=%b", k, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
            if (k == 13) begin
                checks++;
                if (dwell_active !== 1'b0 || throttle !== 2'd3 || btn_db[2] !== 1'b1) begin
                    errors++; $display("FAIL simul_expiry thr=%0d dwell=%b dbf=%b exp thr=3 dwell=0 dbf=1", throttle, dwell_active, btn_db[2]);
                end
            end
            if (k == 14) begin
                checks++;
                if (throttle !== 2'd2) begin errors++; $display("FAIL simul_fwd thr=%0d exp=2", throttle); end
            end
        end
        btn_fwd = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: btn_left  = ~btn_left;
                    1: btn_right = ~btn_right;
                    2: btn_fwd   = ~btn_fwd;
                    default: btn_rev = ~btn_rev;
                endcase
            end
            if (estop) estop = ($urandom_range(7) != 0);
            else       estop = ($urandom_range(149) == 0);
            tick();
            checks++;
            if ({direction, throttle, btn_db, dwell_active} !== exp_vec() || throttle == 2'd0 || direction == 2'd0) begin
                errors++; $display("FAIL random n=%0d got=%b exp=%b", n, {direction, throttle, btn_db, dwell_active}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_debounce();
        test_conflict();
        test_reversal();
        test_estop();
        test_simultaneity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
